// File: rtl/sig_detect_pkg.sv
// Shared types and default parameters for the comparator period qualifier.
package sig_detect_pkg;

   typedef enum logic [1:0] {
      NO_SIGNAL,
      FIRST_EDGE,
      TRACKING,
      LOCKED
   } det_state_t;

   localparam int DEF_PERIOD_WIDTH   = 20;
   localparam int DEF_TIMEOUT_CYCLES = 1000000;
   localparam int DEF_MIN_PERIOD     = 8;
   localparam int DEF_TOL_SHIFT      = 4;
   localparam int DEF_MATCH_COUNT    = 4;

endpackage

// File: rtl/edge_period_counter.sv
// Rising-edge detect on the synchronised input plus a saturating
// cycle counter that restarts at 1 on every rise.
module edge_period_counter
   import sig_detect_pkg::*;
#(
   parameter int PERIOD_WIDTH   = DEF_PERIOD_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sync_signal_in,
   output logic                    rise,
   output logic [PERIOD_WIDTH-1:0] cnt
);

   localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = PERIOD_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [PERIOD_WIDTH-1:0] ONE     = PERIOD_WIDTH'(1);

   logic in_prev;

   assign rise = sync_signal_in & ~in_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_prev <= 1'b0;
         cnt     <= '0;
      end else begin
         in_prev <= sync_signal_in;
         if (rise) begin
            cnt <= ONE;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + ONE;
         end
      end
   end

endmodule

// File: rtl/signal_stable_detector.sv
// Qualifies the comparator square wave: locks after a run of matching
// periods and exports the last accepted period.
module signal_stable_detector
   import sig_detect_pkg::*;
#(
   parameter int PERIOD_WIDTH   = DEF_PERIOD_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int MIN_PERIOD     = DEF_MIN_PERIOD,
   parameter int TOL_SHIFT      = DEF_TOL_SHIFT,
   parameter int MATCH_COUNT    = DEF_MATCH_COUNT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sync_signal_in,
   output logic                    stable,
   output logic [PERIOD_WIDTH-1:0] period,
   output logic                    period_valid,
   output logic                    no_signal
);

   localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);
   localparam logic [PERIOD_WIDTH-1:0] TMO   = PERIOD_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [3:0]              MC    = 4'(MATCH_COUNT);

   det_state_t state;
   det_state_t state_nxt;

   logic                    rise;
   logic [PERIOD_WIDTH-1:0] cnt;
   logic [PERIOD_WIDTH-1:0] ref_period;
   logic [PERIOD_WIDTH-1:0] ref_nxt;
   logic [PERIOD_WIDTH-1:0] period_nxt;
   logic [3:0]              match_cnt;
   logic [3:0]              mc_nxt;
   logic [3:0]              mc_inc;
   logic                    pv_nxt;
   logic                    long_enough;
   logic                    match;
   logic [PERIOD_WIDTH:0]   diff;
   logic [PERIOD_WIDTH:0]   tol;

   edge_period_counter #(
      .PERIOD_WIDTH   (PERIOD_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_cnt (
      .clk            (clk),
      .rst_n          (rst_n),
      .sync_signal_in (sync_signal_in),
      .rise           (rise),
      .cnt            (cnt)
   );

   // One extra bit keeps the absolute difference from wrapping
   assign diff = (cnt >= ref_period) ? ({1'b0, cnt} - {1'b0, ref_period})
                                     : ({1'b0, ref_period} - {1'b0, cnt});
   assign tol         = {1'b0, ref_period >> TOL_SHIFT};
   assign long_enough = (cnt >= MIN_P);
   assign match       = long_enough && (diff <= tol);
   assign mc_inc      = match_cnt + 4'd1;

   always_comb begin
      state_nxt  = state;
      ref_nxt    = ref_period;
      mc_nxt     = match_cnt;
      period_nxt = period;
      pv_nxt     = 1'b0;
      if (rise) begin
         if (state != NO_SIGNAL && long_enough) begin
            period_nxt = cnt;
            pv_nxt     = 1'b1;
         end
         unique case (state)
            NO_SIGNAL: state_nxt = FIRST_EDGE;
            FIRST_EDGE: begin
               if (long_enough) begin
                  ref_nxt   = cnt;
                  mc_nxt    = 4'd0;
                  state_nxt = TRACKING;
               end
            end
            TRACKING: begin
               if (!long_enough) begin
                  state_nxt = FIRST_EDGE;
                  mc_nxt    = 4'd0;
               end else if (match) begin
                  ref_nxt = cnt;
                  mc_nxt  = mc_inc;
                  if (mc_inc == MC) state_nxt = LOCKED;
               end else begin
                  ref_nxt = cnt;
                  mc_nxt  = 4'd0;
               end
            end
            LOCKED: begin
               if (!long_enough) begin
                  state_nxt = FIRST_EDGE;
               end else if (match) begin
                  ref_nxt = cnt;
               end else begin
                  state_nxt = TRACKING;
                  ref_nxt   = cnt;
                  mc_nxt    = 4'd0;
               end
            end
            default: state_nxt = NO_SIGNAL;
         endcase
      end else if (state != NO_SIGNAL && cnt == TMO) begin
         state_nxt = NO_SIGNAL;
         mc_nxt    = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= NO_SIGNAL;
         ref_period   <= '0;
         match_cnt    <= 4'd0;
         period       <= '0;
         period_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         ref_period   <= ref_nxt;
         match_cnt    <= mc_nxt;
         period       <= period_nxt;
         period_valid <= pv_nxt;
      end
   end

   assign stable    = (state == LOCKED);
   assign no_signal = (state == NO_SIGNAL);

endmodule

// File: tb/tb_signal_stable_detector.sv
// Self-checking bench: default build plus a short-timeout build fed the
// same waveform, both compared every cycle against a timestamp model.
module tb_signal_stable_detector;

   localparam int PW   = 20;
   localparam int TO_A = 1000000;
   localparam int TO_B = 200;
   localparam int MINP = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sig = 1'b0;
   logic          stable_a, stable_b;
   logic          pv_a, pv_b;
   logic          nosig_a, nosig_b;
   logic [PW-1:0] period_a, period_b;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   signal_stable_detector dut_a (
      .clk            (clk),
      .rst_n          (rst_n),
      .sync_signal_in (sig),
      .stable         (stable_a),
      .period         (period_a),
      .period_valid   (pv_a),
      .no_signal      (nosig_a)
   );

   signal_stable_detector #(
      .TIMEOUT_CYCLES (TO_B)
   ) dut_b (
      .clk            (clk),
      .rst_n          (rst_n),
      .sync_signal_in (sig),
      .stable         (stable_b),
      .period         (period_b),
      .period_valid   (pv_b),
      .no_signal      (nosig_b)
   );

   // Model state: phase 0=no signal, 1=first edge, 2=tracking, 3=locked
   typedef struct {
      int phase;
      int last;
      int ref_p;
      int mc;
      int period;
      bit pv;
      bit prev;
   } mdl_t;

   mdl_t ma, mb;

   typedef struct {
      int p;
      int n;
      bit stable;
      int period;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, exp);
      end
   endtask

   task automatic mstep(input mdl_t mi, input int to, input bit x,
                        input bit rn, input int t, output mdl_t mo);
      int el;
      bit ok;
      mo = mi;
      mo.pv = 1'b0;
      if (!rn) begin
         mo.phase = 0; mo.ref_p = 0; mo.mc = 0;
         mo.period = 0; mo.prev = 1'b0; mo.last = t;
         return;
      end
      mo.prev = x;
      el = t - mi.last;
      if (x && !mi.prev) begin
         if (mi.phase == 0) begin
            mo.phase = 1;
         end else if (el < MINP) begin
            mo.phase = 1;
            mo.mc = 0;
         end else begin
            mo.pv = 1'b1;
            mo.period = el;
            if (mi.phase == 1) begin
               mo.ref_p = el; mo.mc = 0; mo.phase = 2;
            end else begin
               ok = ((el > mi.ref_p) ? el - mi.ref_p : mi.ref_p - el)
                    <= (mi.ref_p >> 4);
               mo.ref_p = el;
               if (mi.phase == 2) begin
                  if (ok) begin
                     mo.mc = mi.mc + 1;
                     if (mo.mc == 4) mo.phase = 3;
                  end else begin
                     mo.mc = 0;
                  end
               end else if (!ok) begin
                  mo.phase = 2;
                  mo.mc = 0;
               end
            end
         end
         mo.last = t;
      end else if (mi.phase != 0 && el >= to) begin
         mo.phase = 0;
         mo.mc = 0;
      end
   endtask

   task automatic step(input bit x, input bit rn);
      sig = x;
      rst_n = rn;
      @(posedge clk);
      mstep(ma, TO_A, x, rn, cyc, ma);
      mstep(mb, TO_B, x, rn, cyc, mb);
      cyc++;
      #1;
      chk("a_stable", stable_a, ma.phase == 3);
      chk("a_no_signal", nosig_a, ma.phase == 0);
      chk("a_period", period_a, ma.period);
      chk("a_period_valid", pv_a, ma.pv);
      chk("b_stable", stable_b, mb.phase == 3);
      chk("b_no_signal", nosig_b, mb.phase == 0);
      chk("b_period", period_b, mb.period);
      chk("b_period_valid", pv_b, mb.pv);
   endtask

   task automatic wave(input int p, input int n);
      for (int k = 0; k < n; k++)
         for (int i = 0; i < p; i++)
            step(i < p / 2, 1'b1);
   endtask

   task automatic chk_reset_values();
      chk("rst_a_stable", stable_a, 0);
      chk("rst_a_period", period_a, 0);
      chk("rst_a_pv", pv_a, 0);
      chk("rst_a_no_signal", nosig_a, 1);
      chk("rst_b_stable", stable_b, 0);
      chk("rst_b_no_signal", nosig_b, 1);
   endtask

   initial begin
      int r;
      ma = '{default: 0};
      mb = '{default: 0};

      // Each row measures the previous row's period on its first rise
      tbl[0] = '{p: 100, n: 6, stable: 1'b1, period: 100};
      tbl[1] = '{p: 106, n: 1, stable: 1'b1, period: 100};
      tbl[2] = '{p: 100, n: 1, stable: 1'b1, period: 106};
      tbl[3] = '{p: 100, n: 1, stable: 1'b1, period: 100};
      tbl[4] = '{p: 107, n: 1, stable: 1'b1, period: 100};
      tbl[5] = '{p: 100, n: 1, stable: 1'b0, period: 107};
      tbl[6] = '{p: 100, n: 3, stable: 1'b0, period: 100};
      tbl[7] = '{p: 100, n: 2, stable: 1'b1, period: 100};

      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk_reset_values();

      for (int i = 0; i < 8; i++) begin
         wave(tbl[i].p, tbl[i].n);
         chk("tbl_stable", stable_a, tbl[i].stable);
         chk("tbl_period", period_a, tbl[i].period);
         chk("tbl_no_signal", nosig_a, 0);
      end

      // Glitch: extra rise 5 cycles after a good one
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      chk("glitch_pv", pv_a, 0);
      chk("glitch_stable", stable_a, 0);
      chk("glitch_period", period_a, 100);
      for (int i = 1; i < 100; i++) step(i < 50, 1'b1);
      wave(100, 4);
      chk("glitch_relock_pending", stable_a, 0);
      wave(100, 1);
      chk("glitch_relock", stable_a, 1);

      // Loss of signal: input held high
      for (int i = 0; i < 250; i++) step(1'b1, 1'b1);
      chk("timeout_b_no_signal", nosig_b, 1);
      chk("timeout_b_stable", stable_b, 0);
      chk("timeout_a_held", stable_a, 1);
      step(1'b0, 1'b1);
      wave(100, 5);
      chk("resume_a_pending", stable_a, 0);
      chk("resume_b_pending", stable_b, 0);
      wave(100, 1);
      chk("resume_a_lock", stable_a, 1);
      chk("resume_b_lock", stable_b, 1);

      // Rise on the same cycle the counter reaches the short timeout
      wave(200, 8);
      chk("simul_b_stable", stable_b, 1);
      chk("simul_b_no_signal", nosig_b, 0);
      chk("simul_b_period", period_b, 200);

      // Reset while locked
      step(1'b0, 1'b0);
      chk_reset_values();
      wave(100, 5);
      chk("post_rst_pending", stable_a, 0);
      wave(100, 1);
      chk("post_rst_lock", stable_a, 1);

      for (int s = 0; s < 150; s++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            wave($urandom_range(2, 9), 1);
         end else if (r == 1) begin
            for (int i = $urandom_range(150, 260); i > 0; i--)
               step(1'b1, 1'b1);
         end else if (r == 2 && $urandom_range(0, 3) == 0) begin
            step($urandom_range(0, 1) == 1, 1'b0);
         end else begin
            wave($urandom_range(92, 108), 1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
